// File: rtl/mem_access_unit_if.sv
// Bus interfaces for mem_access_unit: pipeline-side request/response and
// the datamem-side access port.
`timescale 1ns/1ps

interface mau_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [3:0]  req_size;
    logic        req_signed;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [63:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
        input  req_ready, resp_valid, resp_error, resp_rdata
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
        output req_ready, resp_valid, resp_error, resp_rdata
    );
endinterface

interface mau_mem_if;
    logic [63:0] mem_address;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [63:0] mem_write_data;
    logic [3:0]  mem_xfer_size;
    logic [63:0] mem_read_data;

    modport master (
        output mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_xfer_size,
        input  mem_read_data
    );
    modport slave (
        input  mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_xfer_size,
        output mem_read_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator toward datamem: classifies each request, issues one
// aligned beat or a run of byte beats, and returns an extended load result.
`timescale 1ns/1ps

module mem_access_unit #(
    parameter int unsigned MEM_SIZE         = 1024,
    parameter bit          SPLIT_MISALIGNED = 1'b1
) (
    input logic       clk,
    input logic       reset,
    mau_req_if.slave  req,
    mau_mem_if.master mem
);
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT = 2'd1, RESP = 2'd2} state_e;

    function automatic logic [63:0] size_mask(input logic [3:0] size);
        case (size)
            4'd1:    return 64'h0000_0000_0000_00FF;
            4'd2:    return 64'h0000_0000_0000_FFFF;
            4'd4:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] val, input logic [3:0] size,
                                           input logic sgn);
        logic msb;
        case (size)
            4'd1:    msb = val[7];
            4'd2:    msb = val[15];
            4'd4:    msb = val[31];
            default: msb = 1'b0;
        endcase
        return (val & size_mask(size)) | ((sgn && msb) ? ~size_mask(size) : 64'h0);
    endfunction

    state_e      state_q, state_d;
    logic        write_q, write_d, signed_q, signed_d, split_q, split_d;
    logic [63:0] addr_q, addr_d, wdata_q, wdata_d, asm_q, asm_d;
    logic [3:0]  size_q, size_d;
    logic [2:0]  beat_q, beat_d, last_q, last_d;
    logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, resp_error_q, resp_error_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic [63:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d, mem_re_q, mem_re_d;
    logic [3:0]  mem_xfer_q, mem_xfer_d;

    logic        accept_s, size_ok_s, over_s, mis_s, err_s;
    logic [64:0] end_s;
    logic [2:0]  k_next_s;
    logic [63:0] asm_next_s;

    // Request classification; the end address is 65 bits so wrap-around is an error.
    always_comb begin
        accept_s = req.req_valid && req_ready_q;
        case (req.req_size)
            4'd1, 4'd2, 4'd4, 4'd8: size_ok_s = 1'b1;
            default:                size_ok_s = 1'b0;
        endcase
        end_s  = {1'b0, req.req_addr} + {61'd0, req.req_size};
        over_s = end_s > 65'(MEM_SIZE);
        mis_s  = (req.req_addr[3:0] & (req.req_size - 4'd1)) != 4'd0;
        err_s  = !size_ok_s || over_s || (mis_s && !SPLIT_MISALIGNED);
    end

    // Merge the current beat's read data into the assembly register.
    always_comb begin
        k_next_s   = beat_q + 3'd1;
        asm_next_s = asm_q;
        if (split_q) begin
            asm_next_s[{beat_q, 3'b000} +: 8] = mem.mem_read_data[7:0];
        end else begin
            asm_next_s = mem.mem_read_data & size_mask(size_q);
        end
    end

    // Next-state and next-output logic; memory outputs default to idle values.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        signed_d     = signed_q;
        split_d      = split_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        beat_d       = beat_q;
        last_d       = last_q;
        asm_d        = asm_q;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = 64'h0;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        mem_wdata_d  = 64'h0;
        mem_xfer_d   = 4'd8;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    write_d  = req.req_write;
                    signed_d = req.req_signed;
                    addr_d   = req.req_addr;
                    wdata_d  = req.req_wdata;
                    size_d   = req.req_size;
                    beat_d   = 3'd0;
                    asm_d    = 64'h0;
                    split_d  = mis_s;
                    last_d   = mis_s ? (req.req_size[2:0] - 3'd1) : 3'd0;
                    if (err_s) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = 64'h0;
                    end else begin
                        state_d     = BEAT;
                        mem_addr_d  = req.req_addr;
                        mem_we_d    = req.req_write;
                        mem_re_d    = !req.req_write;
                        mem_xfer_d  = mis_s ? 4'd1 : req.req_size;
                        mem_wdata_d = mis_s ? {56'h0, req.req_wdata[7:0]} : req.req_wdata;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BEAT: begin
                asm_d = asm_next_s;
                if (beat_q == last_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = write_q ? 64'h0 : extend(asm_next_s, size_q, signed_q);
                end else begin
                    beat_d      = k_next_s;
                    mem_addr_d  = addr_q + {61'd0, k_next_s};
                    mem_we_d    = write_q;
                    mem_re_d    = !write_q;
                    mem_xfer_d  = 4'd1;
                    mem_wdata_d = {56'h0, wdata_q[{k_next_s, 3'b000} +: 8]};
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // State and registered outputs; reset aborts any request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            split_q      <= 1'b0;
            addr_q       <= 64'h0;
            wdata_q      <= 64'h0;
            size_q       <= 4'd0;
            beat_q       <= 3'd0;
            last_q       <= 3'd0;
            asm_q        <= 64'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 64'h0;
            mem_addr_q   <= 64'h0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_wdata_q  <= 64'h0;
            mem_xfer_q   <= 4'd8;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            signed_q     <= signed_d;
            split_q      <= split_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            beat_q       <= beat_d;
            last_q       <= last_d;
            asm_q        <= asm_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_xfer_q   <= mem_xfer_d;
        end
    end

    assign req.req_ready        = req_ready_q;
    assign req.resp_valid       = resp_valid_q;
    assign req.resp_error       = resp_error_q;
    assign req.resp_rdata       = resp_rdata_q;
    assign mem.mem_address      = mem_addr_q;
    assign mem.mem_write_enable = mem_we_q;
    assign mem.mem_read_enable  = mem_re_q;
    assign mem.mem_write_data   = mem_wdata_q;
    assign mem.mem_xfer_size    = mem_xfer_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array datamem model, a vector table of
// requests with hand-computed results, and hand sequences for beats and reset.
`timescale 1ns/1ps

module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset;
    logic mem_clear;
    always #5 clk = ~clk;

    mau_req_if ra();
    mau_mem_if ma();
    mau_req_if rb();
    mau_mem_if mb();

    mem_access_unit #(.MEM_SIZE(1024), .SPLIT_MISALIGNED(1'b1)) dut_a (
        .clk(clk), .reset(reset), .req(ra), .mem(ma));
    mem_access_unit #(.MEM_SIZE(1024), .SPLIT_MISALIGNED(1'b0)) dut_b (
        .clk(clk), .reset(reset), .req(rb), .mem(mb));

    logic [7:0]  mem_a [0:1023];
    logic [63:0] log_addr [0:63];
    logic [63:0] log_data [0:63];
    logic [3:0]  log_xfer [0:63];
    int beats_a = 0;
    int beats_b = 0;
    int resp_cnt_a = 0;
    int n_cmp = 0;
    int n_fail = 0;

    // Little-endian datamem model: combinational read, posedge write.
    always_comb begin
        ma.mem_read_data = 64'h0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(ma.mem_xfer_size) && (ma.mem_address + 64'(i)) < 64'd1024)
                ma.mem_read_data[8*i +: 8] = mem_a[ma.mem_address[9:0] + 10'(i)];
        end
    end
    assign mb.mem_read_data = 64'h0;

    always_ff @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem_a[i] <= 8'h00;
        end else if (ma.mem_write_enable) begin
            for (int i = 0; i < 8; i++) begin
                if (i < int'(ma.mem_xfer_size) && (ma.mem_address + 64'(i)) < 64'd1024)
                    mem_a[ma.mem_address[9:0] + 10'(i)] <= ma.mem_write_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ma.mem_write_enable || ma.mem_read_enable) begin
            log_addr[beats_a[5:0]] <= ma.mem_address;
            log_data[beats_a[5:0]] <= ma.mem_write_data;
            log_xfer[beats_a[5:0]] <= ma.mem_xfer_size;
            beats_a <= beats_a + 1;
        end
        if (mb.mem_write_enable || mb.mem_read_enable) beats_b <= beats_b + 1;
        if (ra.resp_valid) resp_cnt_a <= resp_cnt_a + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_req(input bit which, input bit no_wait, input bit wr,
                          input logic [63:0] addr, input logic [3:0] size, input bit sgn,
                          input logic [63:0] wd, output int lat, output logic err,
                          output logic [63:0] rd, output int beats, output int first);
        logic [7:0] idle_s;
        if (!no_wait) @(negedge clk);
        first = which ? beats_b : beats_a;
        if (which) begin
            rb.req_write = wr; rb.req_addr = addr; rb.req_size = size;
            rb.req_signed = sgn; rb.req_wdata = wd; rb.req_valid = 1'b1;
        end else begin
            ra.req_write = wr; ra.req_addr = addr; ra.req_size = size;
            ra.req_signed = sgn; ra.req_wdata = wd; ra.req_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        ra.req_valid = 1'b0;
        rb.req_valid = 1'b0;
        lat = 0; err = 1'bx; rd = 64'hx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (which ? rb.resp_valid : ra.resp_valid) begin
                lat = c;
                err = which ? rb.resp_error : ra.resp_error;
                rd  = which ? rb.resp_rdata : ra.resp_rdata;
                idle_s = which ?
                    {mb.mem_write_enable, mb.mem_read_enable, rb.req_ready, mb.mem_xfer_size,
                     mb.mem_address != 64'h0} :
                    {ma.mem_write_enable, ma.mem_read_enable, ra.req_ready, ma.mem_xfer_size,
                     ma.mem_address != 64'h0};
                chk("resp_cycle_idle", 64'(idle_s), 64'(8'b000_1000_0));
                break;
            end
        end
        beats = (which ? beats_b : beats_a) - first;
    endtask

    typedef struct {
        string       name;
        bit          wr;
        logic [63:0] addr;
        logic [3:0]  size;
        bit          sgn;
        logic [63:0] wd;
        logic        exp_err;
        int          exp_lat;
        int          exp_beats;
        logic [63:0] exp_rd;
    } vec_t;

    function automatic vec_t mk(input string nm, input bit wr, input logic [63:0] addr,
                                input logic [3:0] size, input bit sgn, input logic [63:0] wd,
                                input logic e, input int lat, input int bt, input logic [63:0] rd);
        vec_t v;
        v.name = nm; v.wr = wr; v.addr = addr; v.size = size; v.sgn = sgn; v.wd = wd;
        v.exp_err = e; v.exp_lat = lat; v.exp_beats = bt; v.exp_rd = rd;
        return v;
    endfunction

    vec_t tbl [23];

    initial begin
        int lat, beats, first, r0;
        logic err;
        logic [63:0] rd;
        logic [7:0] exp_b [4];

        tbl[0]  = mk("ld8_40",      0, 64'h40, 4'd8, 0, 64'h0, 0, 2, 1, 64'h1122334455667788);
        tbl[1]  = mk("ld4u_10",     0, 64'h10, 4'd4, 0, 64'h0, 0, 2, 1, 64'h00000000DD000000);
        tbl[2]  = mk("ld4s_10",     0, 64'h10, 4'd4, 1, 64'h0, 0, 2, 1, 64'hFFFFFFFFDD000000);
        tbl[3]  = mk("ld4u_14",     0, 64'h14, 4'd4, 0, 64'h0, 0, 2, 1, 64'h0000000000AABBCC);
        tbl[4]  = mk("ld4u_13",     0, 64'h13, 4'd4, 0, 64'h0, 0, 5, 4, 64'h00000000AABBCCDD);
        tbl[5]  = mk("ld4s_13",     0, 64'h13, 4'd4, 1, 64'h0, 0, 5, 4, 64'hFFFFFFFFAABBCCDD);
        tbl[6]  = mk("st1_21",      1, 64'h21, 4'd1, 0, 64'hDEADBEEFCAFE5A80, 0, 2, 1, 64'h0);
        tbl[7]  = mk("st1_22",      1, 64'h22, 4'd1, 0, 64'h00000000000000FF, 0, 2, 1, 64'h0);
        tbl[8]  = mk("ld1s_21",     0, 64'h21, 4'd1, 1, 64'h0, 0, 2, 1, 64'hFFFFFFFFFFFFFF80);
        tbl[9]  = mk("ld1u_21",     0, 64'h21, 4'd1, 0, 64'h0, 0, 2, 1, 64'h0000000000000080);
        tbl[10] = mk("ld2s_21",     0, 64'h21, 4'd2, 1, 64'h0, 0, 3, 2, 64'hFFFFFFFFFFFFFF80);
        tbl[11] = mk("ld2u_21",     0, 64'h21, 4'd2, 0, 64'h0, 0, 3, 2, 64'h000000000000FF80);
        tbl[12] = mk("st8_03",      1, 64'h03, 4'd8, 0, 64'h0807060504030201, 0, 9, 8, 64'h0);
        tbl[13] = mk("ld8_00",      0, 64'h00, 4'd8, 0, 64'h0, 0, 2, 1, 64'h0504030201000000);
        tbl[14] = mk("ld8_08",      0, 64'h08, 4'd8, 1, 64'h0, 0, 2, 1, 64'h0000000000080706);
        tbl[15] = mk("ld8_3f8",     0, 64'h3F8, 4'd8, 0, 64'h0, 0, 2, 1, 64'h0);
        tbl[16] = mk("err_ld8_3fc", 0, 64'h3FC, 4'd8, 0, 64'h0, 1, 1, 0, 64'h0);
        tbl[17] = mk("err_size3",   0, 64'h0, 4'd3, 0, 64'h0, 1, 1, 0, 64'h0);
        tbl[18] = mk("err_wrap",    0, 64'hFFFFFFFFFFFFFFFF, 4'd2, 0, 64'h0, 1, 1, 0, 64'h0);
        tbl[19] = mk("err_size0",   0, 64'h0, 4'd0, 0, 64'h0, 1, 1, 0, 64'h0);
        tbl[20] = mk("err_st2_3ff", 1, 64'h3FF, 4'd2, 0, 64'h1234, 1, 1, 0, 64'h0);
        tbl[21] = mk("ld1_3ff",     0, 64'h3FF, 4'd1, 1, 64'h0, 0, 2, 1, 64'h0);
        tbl[22] = mk("ld2_3fe",     0, 64'h3FE, 4'd2, 0, 64'h0, 0, 2, 1, 64'h0);

        ra.req_valid = 1'b0; ra.req_write = 1'b0; ra.req_addr = 64'h0;
        ra.req_size = 4'd0; ra.req_signed = 1'b0; ra.req_wdata = 64'h0;
        rb.req_valid = 1'b0; rb.req_write = 1'b0; rb.req_addr = 64'h0;
        rb.req_size = 4'd0; rb.req_signed = 1'b0; rb.req_wdata = 64'h0;
        reset = 1'b1;
        mem_clear = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {57'h0, ra.req_ready, ra.resp_valid, ra.resp_error,
                              ma.mem_write_enable, ma.mem_read_enable, ma.mem_xfer_size == 4'd8,
                              ma.mem_address == 64'h0}, 64'b1000011);
        chk("reset_rdata", ra.resp_rdata, 64'h0);
        chk("reset_wdata", ma.mem_write_data, 64'h0);
        reset = 1'b0;
        mem_clear = 1'b0;

        // Aligned 8-byte store: one write beat with the whole word.
        do_req(0, 0, 1, 64'h40, 4'd8, 0, 64'h1122334455667788, lat, err, rd, beats, first);
        chk("st8_40_lat", 64'(lat), 64'd2);
        chk("st8_40_beats", 64'(beats), 64'd1);
        chk("st8_40_addr", log_addr[first[5:0]], 64'h40);
        chk("st8_40_xfer", 64'(log_xfer[first[5:0]]), 64'd8);
        chk("st8_40_data", log_data[first[5:0]], 64'h1122334455667788);

        // Misaligned 4-byte store: four byte beats at consecutive addresses.
        exp_b[0] = 8'hDD; exp_b[1] = 8'hCC; exp_b[2] = 8'hBB; exp_b[3] = 8'hAA;
        do_req(0, 0, 1, 64'h13, 4'd4, 0, 64'h00000000AABBCCDD, lat, err, rd, beats, first);
        chk("st4_13_lat", 64'(lat), 64'd5);
        chk("st4_13_beats", 64'(beats), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("st4_13_addr", log_addr[6'(first + k)], 64'h13 + 64'(k));
            chk("st4_13_xfer", 64'(log_xfer[6'(first + k)]), 64'd1);
            chk("st4_13_data", log_data[6'(first + k)], {56'h0, exp_b[k]});
        end

        for (int i = 0; i < 23; i++) begin
            do_req(0, 0, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].sgn, tbl[i].wd,
                   lat, err, rd, beats, first);
            chk({tbl[i].name, "_lat"}, 64'(lat), 64'(tbl[i].exp_lat));
            chk({tbl[i].name, "_err"}, 64'(err), 64'(tbl[i].exp_err));
            chk({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rd);
            chk({tbl[i].name, "_beats"}, 64'(beats), 64'(tbl[i].exp_beats));
        end

        // Unit built without splitting rejects misaligned requests outright.
        do_req(1, 0, 0, 64'h1, 4'd2, 0, 64'h0, lat, err, rd, beats, first);
        chk("nosplit_ld2_1_lat", 64'(lat), 64'd1);
        chk("nosplit_ld2_1_err", 64'(err), 64'd1);
        chk("nosplit_ld2_1_beats", 64'(beats), 64'd0);
        do_req(1, 0, 1, 64'h6, 4'd4, 0, 64'hFFFF, lat, err, rd, beats, first);
        chk("nosplit_st4_6_err", 64'(err), 64'd1);
        chk("nosplit_st4_6_beats", 64'(beats), 64'd0);
        do_req(1, 0, 0, 64'h2, 4'd2, 0, 64'h0, lat, err, rd, beats, first);
        chk("nosplit_ld2_2_lat", 64'(lat), 64'd2);
        chk("nosplit_ld2_2_err", 64'(err), 64'd0);
        chk("nosplit_ld2_2_beats", 64'(beats), 64'd1);

        // Reset lands after two byte beats of a split store.
        @(negedge clk);
        r0 = resp_cnt_a;
        ra.req_write = 1'b1; ra.req_addr = 64'h101; ra.req_size = 4'd8;
        ra.req_signed = 1'b0; ra.req_wdata = 64'h8877665544332211; ra.req_valid = 1'b1;
        @(posedge clk);
        #1;
        ra.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_idle", {60'h0, ma.mem_write_enable, ma.mem_read_enable, ra.resp_valid,
                           ra.req_ready}, 64'b0001);
        reset = 1'b0;
        do_req(0, 1, 0, 64'h100, 4'd8, 0, 64'h0, lat, err, rd, beats, first);
        chk("post_reset_lat", 64'(lat), 64'd2);
        chk("post_reset_rdata", rd, 64'h0000000000221100);
        @(posedge clk);
        #1;
        chk("abort_no_resp", 64'(resp_cnt_a - r0), 64'd1);
        chk("abort_byte_101", 64'(mem_a[10'h101]), 64'h11);
        chk("abort_byte_102", 64'(mem_a[10'h102]), 64'h22);
        for (int a = 10'h103; a <= 10'h108; a++)
            chk("abort_untouched", 64'(mem_a[a]), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
